// File: rtl/rgbd_vo_cfg_regfile_pkg.sv
// Shared types and constants for the RGB-D VO configuration register file.
package rgbd_vo_cfg_regfile_pkg;

    localparam int unsigned BUS_DW   = 32;
    localparam int unsigned ADDR_BW  = 4;
    localparam int unsigned H_BW     = 10;
    localparam int unsigned V_BW     = 10;
    localparam int unsigned FX_BW    = 35;
    localparam int unsigned DEPTH_BW = 16;
    localparam int unsigned FX_HI_BW = FX_BW - BUS_DW;

    localparam int unsigned MAX_WID  = 640;
    localparam int unsigned MAX_HGT  = 480;
    localparam int unsigned DEF_DMAX = 20000;
    localparam int unsigned DEF_DMIN = 0;

    // Host word map; intrinsics occupy LO/HI pairs starting at an odd address.
    typedef enum logic [ADDR_BW-1:0] {
        RegDisable  = 4'd0,
        RegHSize    = 4'd1,
        RegVSize    = 4'd2,
        RegFxLo     = 4'd3,
        RegFxHi     = 4'd4,
        RegFyLo     = 4'd5,
        RegFyHi     = 4'd6,
        RegCxLo     = 4'd7,
        RegCxHi     = 4'd8,
        RegCyLo     = 4'd9,
        RegCyHi     = 4'd10,
        RegDepthMax = 4'd11,
        RegDepthMin = 4'd12,
        RegStatus   = 4'd13,
        RegCommit   = 4'd14
    } reg_addr_e;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StCommit
    } cfg_state_e;

    // intr[0..3] = FX, FY, CX, CY (two's complement fixed point)
    typedef struct packed {
        logic                     dis;
        logic [H_BW-1:0]          h_size;
        logic [V_BW-1:0]          v_size;
        logic [3:0][FX_BW-1:0]    intr;
        logic [DEPTH_BW-1:0]      depth_max;
        logic [DEPTH_BW-1:0]      depth_min;
    } cfg_t;

endpackage

// File: rtl/rgbd_vo_cfg_regfile_if.sv
// Host register bus: valid/ready request, 1-cycle read response.
interface rgbd_vo_cfg_regfile_if;
    import rgbd_vo_cfg_regfile_pkg::*;

    logic               reg_valid;
    logic               reg_ready;
    logic               reg_write;
    logic [ADDR_BW-1:0] reg_addr;
    logic [BUS_DW-1:0]  reg_wdata;
    logic               reg_rvalid;
    logic [BUS_DW-1:0]  reg_rdata;

    modport master (
        output reg_valid, reg_write, reg_addr, reg_wdata,
        input  reg_ready, reg_rvalid, reg_rdata
    );

    modport slave (
        input  reg_valid, reg_write, reg_addr, reg_wdata,
        output reg_ready, reg_rvalid, reg_rdata
    );
endinterface

// File: rtl/rgbd_vo_cfg_check.sv
// Combinational legality check of a candidate configuration set.
module rgbd_vo_cfg_check
    import rgbd_vo_cfg_regfile_pkg::*;
#(
    parameter int unsigned MAX_WID = rgbd_vo_cfg_regfile_pkg::MAX_WID,
    parameter int unsigned MAX_HGT = rgbd_vo_cfg_regfile_pkg::MAX_HGT
) (
    input  cfg_t cfg_i,
    output logic valid_o
);

    logic h_ok, v_ok, d_ok;
    logic unused_fields;

    // Fields that carry no range constraint.
    assign unused_fields = ^{cfg_i.dis, cfg_i.intr};

    // Frame size must be non-zero and within the sensor limits; depth window non-inverted.
    always_comb begin
        h_ok    = (cfg_i.h_size != '0) && (32'(cfg_i.h_size) <= MAX_WID);
        v_ok    = (cfg_i.v_size != '0) && (32'(cfg_i.v_size) <= MAX_HGT);
        d_ok    = (cfg_i.depth_min <= cfg_i.depth_max);
        valid_o = h_ok & v_ok & d_ok;
    end

endmodule

// File: rtl/rgbd_vo_cfg_regfile.sv
// Shadow/active configuration register file with validated atomic frame-start commit.
module rgbd_vo_cfg_regfile
    import rgbd_vo_cfg_regfile_pkg::*;
#(
    parameter int unsigned MAX_WID  = rgbd_vo_cfg_regfile_pkg::MAX_WID,
    parameter int unsigned MAX_HGT  = rgbd_vo_cfg_regfile_pkg::MAX_HGT,
    parameter int unsigned DEF_DMAX = rgbd_vo_cfg_regfile_pkg::DEF_DMAX,
    parameter int unsigned DEF_DMIN = rgbd_vo_cfg_regfile_pkg::DEF_DMIN
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    rgbd_vo_cfg_regfile_if.slave    bus,
    input  logic                    i_frame_start,
    output logic                    o_cfg_update,
    output logic                    o_disable,
    output logic [H_BW-1:0]         o_h_size,
    output logic [V_BW-1:0]         o_v_size,
    output logic [FX_BW-1:0]        o_fx,
    output logic [FX_BW-1:0]        o_fy,
    output logic [FX_BW-1:0]        o_cx,
    output logic [FX_BW-1:0]        o_cy,
    output logic [DEPTH_BW-1:0]     o_depth_max,
    output logic [DEPTH_BW-1:0]     o_depth_min,
    output logic                    o_cfg_err
);

    localparam cfg_t CfgRst = '{
        dis:       1'b1,
        h_size:    H_BW'(MAX_WID),
        v_size:    V_BW'(MAX_HGT),
        intr:      '0,
        depth_max: DEPTH_BW'(DEF_DMAX),
        depth_min: DEPTH_BW'(DEF_DMIN)
    };

    cfg_state_e        state_q, state_d;
    cfg_t              shadow_q, shadow_d;
    cfg_t              active_q, active_d;
    logic              pending_q, pending_d;
    logic              err_q, err_d;
    logic              rvalid_q;
    logic [BUS_DW-1:0] rdata_q;
    logic [BUS_DW-1:0] rd_mux;

    logic              wr_acc, rd_acc;
    logic              busy;
    logic              shadow_valid;
    logic [1:0]        intr_idx;

    rgbd_vo_cfg_check #(
        .MAX_WID (MAX_WID),
        .MAX_HGT (MAX_HGT)
    ) u_check (
        .cfg_i   (shadow_q),
        .valid_o (shadow_valid)
    );

    // Shadow is frozen while a commit is in flight by refusing host requests.
    assign busy          = (state_q != StIdle);
    assign bus.reg_ready = ~busy;
    assign wr_acc        = bus.reg_valid & ~busy & bus.reg_write;
    assign rd_acc        = bus.reg_valid & ~busy & ~bus.reg_write;
    // Addresses 3..10 map pairwise onto intr[0..3].
    assign intr_idx      = 2'((bus.reg_addr - ADDR_BW'(3)) >> 1);

    // Host write decode and commit FSM next-state.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        err_d     = err_q;

        if (wr_acc) begin
            case (reg_addr_e'(bus.reg_addr))
                RegDisable: begin
                    shadow_d.dis = bus.reg_wdata[0];
                    pending_d    = 1'b1;
                end
                RegHSize: begin
                    shadow_d.h_size = bus.reg_wdata[H_BW-1:0];
                    pending_d       = 1'b1;
                end
                RegVSize: begin
                    shadow_d.v_size = bus.reg_wdata[V_BW-1:0];
                    pending_d       = 1'b1;
                end
                RegFxLo, RegFyLo, RegCxLo, RegCyLo: begin
                    shadow_d.intr[intr_idx][BUS_DW-1:0] = bus.reg_wdata;
                    pending_d                           = 1'b1;
                end
                RegFxHi, RegFyHi, RegCxHi, RegCyHi: begin
                    shadow_d.intr[intr_idx][FX_BW-1:BUS_DW] = bus.reg_wdata[FX_HI_BW-1:0];
                    pending_d                               = 1'b1;
                end
                RegDepthMax: begin
                    shadow_d.depth_max = bus.reg_wdata[DEPTH_BW-1:0];
                    pending_d          = 1'b1;
                end
                RegDepthMin: begin
                    shadow_d.depth_min = bus.reg_wdata[DEPTH_BW-1:0];
                    pending_d          = 1'b1;
                end
                RegStatus: begin
                    if (bus.reg_wdata[1]) begin
                        err_d = 1'b0;
                    end
                end
                RegCommit: pending_d = 1'b1;
                default: ;
            endcase
        end

        case (state_q)
            StIdle: begin
                if (pending_q && (i_frame_start || shadow_q.dis)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                pending_d = 1'b0;
                if (shadow_valid) begin
                    // Whole set lands in one edge, so no partial update is ever observable.
                    active_d = shadow_q;
                    err_d    = 1'b0;
                    state_d  = StCommit;
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Read mux over the shadow set and status.
    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(bus.reg_addr))
            RegDisable:  rd_mux = BUS_DW'(shadow_q.dis);
            RegHSize:    rd_mux = BUS_DW'(shadow_q.h_size);
            RegVSize:    rd_mux = BUS_DW'(shadow_q.v_size);
            RegFxLo, RegFyLo, RegCxLo, RegCyLo:
                rd_mux = shadow_q.intr[intr_idx][BUS_DW-1:0];
            RegFxHi, RegFyHi, RegCxHi, RegCyHi:
                rd_mux = BUS_DW'(shadow_q.intr[intr_idx][FX_BW-1:BUS_DW]);
            RegDepthMax: rd_mux = BUS_DW'(shadow_q.depth_max);
            RegDepthMin: rd_mux = BUS_DW'(shadow_q.depth_min);
            RegStatus:   rd_mux = BUS_DW'({busy, err_q, pending_q});
            default:     rd_mux = '0;
        endcase
    end

    // State, shadow/active sets and registered read response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            shadow_q  <= CfgRst;
            active_q  <= CfgRst;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            rvalid_q  <= rd_acc;
            if (rd_acc) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign bus.reg_rvalid = rvalid_q;
    assign bus.reg_rdata  = rdata_q;

    assign o_cfg_update = (state_q == StCommit);
    assign o_cfg_err    = err_q;
    assign o_disable    = active_q.dis;
    assign o_h_size     = active_q.h_size;
    assign o_v_size     = active_q.v_size;
    assign o_fx         = active_q.intr[0];
    assign o_fy         = active_q.intr[1];
    assign o_cx         = active_q.intr[2];
    assign o_cy         = active_q.intr[3];
    assign o_depth_max  = active_q.depth_max;
    assign o_depth_min  = active_q.depth_min;

endmodule
